clock_mode_ctrl: RTL

Mode and time-setting controller for the six-digit digital clock / chronometer. It generates the 1 Hz count enables that drive the time-of-day and chronometer counter chains. It runs a four-state user-mode FSM that freezes the clock for hour/minute setting and issues single-cycle increment pulses with press-and-hold auto-repeat. It also drives blink masks for the 7-segment display driver.

---
 rtl/clock_mode_ctrl.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/clock_mode_ctrl.sv
// Mode/time-setting controller for the six-digit clock: 1 Hz enables, user-mode FSM,
// hour/minute increment with press-and-hold auto-repeat, and display blink masks.
module clock_mode_ctrl #(
    parameter int TICK_DIV     = 50_000_000,
    parameter int BLINK_HALF   = 12_500_000,
    parameter int REPEAT_DELAY = 25_000_000,
    parameter int REPEAT_RATE  = 5_000_000
) (
    input  logic       clk,
    input  logic       res,
    input  logic       btn_mode,
    input  logic       btn_plus,
    input  logic       btn_start,
    output logic       tick_en,
    output logic       sec_clr,
    output logic       inc_min,
    output logic       inc_hour,
    output logic       chrono_tick,
    output logic       chrono_clr,
    output logic       chrono_run,
    output logic [2:0] blink_mask,
    output logic [1:0] mode
);
    localparam int TW   = $clog2(TICK_DIV);
    localparam int BW   = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RW   = (RMAX > 1) ? $clog2(RMAX) : 1;

    localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);
    localparam logic [RW-1:0] DELAY_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RATE_LAST  = RW'(REPEAT_RATE - 1);

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_SET_HOUR = 2'b01,
        ST_SET_MIN  = 2'b10,
        ST_CHRONO   = 2'b11
    } state_t;

    state_t          state_reg, state_next;
    logic [2:0]      meta_reg, sync_reg, dly_reg, rise_reg;
    logic [TW-1:0]   tick_cnt_reg;
    logic [BW-1:0]   blink_cnt_reg;
    logic            phase_reg, phase_next;
    logic [RW-1:0]   rep_cnt_reg;
    logic            rep_active_reg, repeating_reg;

    logic mode_rise, plus_rise, start_rise, plus_held, in_set, base;
    logic rep_fire, inc_next, clr_next, toggle_next, sec_clr_next, restart;

    // Button bits: 0 = mode, 1 = plus, 2 = start
    assign mode_rise  = rise_reg[0];
    assign plus_rise  = rise_reg[1];
    assign start_rise = rise_reg[2];
    // The delay flop is the button level aligned with the registered rise
    assign plus_held  = dly_reg[1];
    assign in_set     = (state_reg == ST_SET_HOUR) || (state_reg == ST_SET_MIN);
    assign base       = (tick_cnt_reg == TICK_LAST);
    assign mode       = state_reg;

    assign rep_fire = rep_active_reg && plus_held &&
                      (repeating_reg ? (rep_cnt_reg == RATE_LAST) : (rep_cnt_reg == DELAY_LAST));

    always_comb begin
        state_next   = state_reg;
        sec_clr_next = 1'b0;
        inc_next     = 1'b0;
        clr_next     = 1'b0;
        toggle_next  = 1'b0;
        if (mode_rise) begin
            // A mode press wins; any same-cycle plus/start rise is dropped
            case (state_reg)
                ST_RUN:      state_next = ST_SET_HOUR;
                ST_SET_HOUR: state_next = ST_SET_MIN;
                ST_SET_MIN: begin
                    state_next   = ST_RUN;
                    sec_clr_next = 1'b1;
                end
                default:     state_next = ST_RUN;
            endcase
        end else begin
            case (state_reg)
                ST_RUN:      if (start_rise) state_next = ST_CHRONO;
                ST_SET_HOUR,
                ST_SET_MIN:  inc_next = plus_rise || rep_fire;
                default: begin
                    clr_next    = plus_rise && !chrono_run;
                    toggle_next = start_rise;
                end
            endcase
        end
        restart = (state_next != state_reg) || inc_next;
        if (restart)
            phase_next = 1'b0;
        else if (blink_cnt_reg == BLINK_LAST)
            phase_next = !phase_reg;
        else
            phase_next = phase_reg;
    end

    always_ff @(posedge clk) begin
        if (res) begin
            meta_reg       <= 3'b111;
            sync_reg       <= 3'b111;
            dly_reg        <= 3'b111;
            rise_reg       <= 3'b000;
            state_reg      <= ST_RUN;
            tick_cnt_reg   <= '0;
            blink_cnt_reg  <= '0;
            phase_reg      <= 1'b0;
            rep_cnt_reg    <= '0;
            rep_active_reg <= 1'b0;
            repeating_reg  <= 1'b0;
            tick_en        <= 1'b0;
            sec_clr        <= 1'b0;
            inc_min        <= 1'b0;
            inc_hour       <= 1'b0;
            chrono_tick    <= 1'b0;
            chrono_clr     <= 1'b0;
            chrono_run     <= 1'b0;
            blink_mask     <= 3'b000;
        end else begin
            meta_reg <= {btn_start, btn_plus, btn_mode};
            sync_reg <= meta_reg;
            dly_reg  <= sync_reg;
            rise_reg <= sync_reg & ~dly_reg;

            state_reg <= state_next;

            if (sec_clr_next || base)
                tick_cnt_reg <= '0;
            else
                tick_cnt_reg <= tick_cnt_reg + TW'(1);

            tick_en     <= base && !in_set;
            chrono_tick <= base && chrono_run;
            chrono_run  <= chrono_run ^ toggle_next;
            chrono_clr  <= clr_next;
            sec_clr     <= sec_clr_next;
            inc_hour    <= inc_next && (state_reg == ST_SET_HOUR);
            inc_min     <= inc_next && (state_reg == ST_SET_MIN);

            if ((state_next != state_reg) || !plus_held || !in_set) begin
                rep_active_reg <= 1'b0;
                repeating_reg  <= 1'b0;
                rep_cnt_reg    <= '0;
            end else if (plus_rise) begin
                rep_active_reg <= 1'b1;
                repeating_reg  <= 1'b0;
                rep_cnt_reg    <= '0;
            end else if (rep_active_reg) begin
                if (rep_fire) begin
                    repeating_reg <= 1'b1;
                    rep_cnt_reg   <= '0;
                end else begin
                    rep_cnt_reg <= rep_cnt_reg + RW'(1);
                end
            end

            if (restart || (blink_cnt_reg == BLINK_LAST))
                blink_cnt_reg <= '0;
            else
                blink_cnt_reg <= blink_cnt_reg + BW'(1);
            phase_reg <= phase_next;

            case (state_next)
                ST_SET_HOUR: blink_mask <= {phase_next, 2'b00};
                ST_SET_MIN:  blink_mask <= {1'b0, phase_next, 1'b0};
                default:     blink_mask <= 3'b000;
            endcase
        end
    end
endmodule
